// File: rtl/vend_sequencer.sv
// rtl/vend_sequencer.sv - vending credit accumulator, vend request and greedy change sequencer
module vend_sequencer #(
    parameter int unsigned PRICE0     = 10,
    parameter int unsigned PRICE1     = 15,
    parameter int unsigned PRICE2     = 20,
    parameter int unsigned PRICE3     = 25,
    parameter int unsigned MAX_CREDIT = 150
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       coin_valid_i,
    input  logic [1:0] coin_val_i,
    output logic       coin_rej_o,
    input  logic       sel_valid_i,
    input  logic [1:0] sel_id_i,
    input  logic       cancel_i,
    output logic [7:0] credit_o,
    output logic [3:0] avail_o,
    output logic       vend_req_o,
    output logic [1:0] vend_id_o,
    input  logic       vend_ack_i,
    output logic       chg_req_o,
    output logic [1:0] chg_coin_o,
    input  logic       chg_ack_i,
    output logic       busy_o
);

    typedef enum logic [1:0] {COLLECT, VEND, CHANGE} state_t;

    localparam logic [7:0] P0      = 8'(PRICE0);
    localparam logic [7:0] P1      = 8'(PRICE1);
    localparam logic [7:0] P2      = 8'(PRICE2);
    localparam logic [7:0] P3      = 8'(PRICE3);
    localparam logic [8:0] MAX_CR9 = 9'(MAX_CREDIT);

    state_t     state_q, state_d;
    logic [7:0] credit_q, credit_d;
    logic [1:0] vend_id_q, vend_id_d;
    logic [1:0] chg_coin_q, chg_coin_d;
    logic       coin_rej_q, coin_rej_d;
    logic [8:0] coin_sum;
    logic [7:0] sel_price;

    function automatic logic [7:0] coin_value(input logic [1:0] c);
        case (c)
            2'b00:   return 8'd1;
            2'b01:   return 8'd5;
            2'b10:   return 8'd10;
            default: return 8'd50;
        endcase
    endfunction

    // Largest ejectable denomination not exceeding the given credit.
    function automatic logic [1:0] greedy(input logic [7:0] c);
        if (c >= 8'd50)      return 2'b11;
        else if (c >= 8'd10) return 2'b10;
        else if (c >= 8'd5)  return 2'b01;
        else                 return 2'b00;
    endfunction

    assign avail_o[0] = (credit_q >= P0);
    assign avail_o[1] = (credit_q >= P1);
    assign avail_o[2] = (credit_q >= P2);
    assign avail_o[3] = (credit_q >= P3);

    assign coin_sum = {1'b0, credit_q} + {1'b0, coin_value(coin_val_i)};

    always_comb begin
        case (sel_id_i)
            2'd0:    sel_price = P0;
            2'd1:    sel_price = P1;
            2'd2:    sel_price = P2;
            default: sel_price = P3;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        vend_id_d  = vend_id_q;
        chg_coin_d = chg_coin_q;
        coin_rej_d = 1'b0;
        case (state_q)
            COLLECT: begin
                if (cancel_i) begin
                    coin_rej_d = coin_valid_i;
                    if (credit_q != 8'd0) begin
                        state_d    = CHANGE;
                        chg_coin_d = greedy(credit_q);
                    end
                end else if (coin_valid_i) begin
                    if (coin_sum <= MAX_CR9) credit_d = coin_sum[7:0];
                    else                     coin_rej_d = 1'b1;
                end else if (sel_valid_i && avail_o[sel_id_i]) begin
                    credit_d  = credit_q - sel_price;
                    vend_id_d = sel_id_i;
                    state_d   = VEND;
                end
            end
            VEND: begin
                coin_rej_d = coin_valid_i;
                if (vend_ack_i) begin
                    if (credit_q != 8'd0) begin
                        state_d    = CHANGE;
                        chg_coin_d = greedy(credit_q);
                    end else begin
                        state_d = COLLECT;
                    end
                end
            end
            default: begin
                coin_rej_d = coin_valid_i;
                // Next denomination is chosen from the post-ack credit so it is stable before the next request.
                if (chg_ack_i) begin
                    credit_d   = credit_q - coin_value(chg_coin_q);
                    chg_coin_d = greedy(credit_d);
                    if (credit_d == 8'd0) state_d = COLLECT;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= COLLECT;
            credit_q   <= 8'd0;
            vend_id_q  <= 2'd0;
            chg_coin_q <= 2'd0;
            coin_rej_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            vend_id_q  <= vend_id_d;
            chg_coin_q <= chg_coin_d;
            coin_rej_q <= coin_rej_d;
        end
    end

    assign credit_o   = credit_q;
    assign coin_rej_o = coin_rej_q;
    assign vend_req_o = (state_q == VEND);
    assign chg_req_o  = (state_q == CHANGE);
    assign busy_o     = (state_q != COLLECT);
    assign vend_id_o  = vend_id_q;
    assign chg_coin_o = chg_coin_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// tb/tb_vend_sequencer.sv - scoreboard bench for vend_sequencer with directed vectors
module tb_vend_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       coin_valid, sel_valid, cancel, vend_ack, chg_ack;
    logic [1:0] coin_val, sel_id;
    logic       coin_rej, vend_req, chg_req, busy;
    logic [7:0] credit;
    logic [3:0] avail;
    logic [1:0] vend_id, chg_coin;

    int tests = 0;
    int fails = 0;

    localparam logic [1:0] K_REJ  = 2'd0;
    localparam logic [1:0] K_VEND = 2'd1;
    localparam logic [1:0] K_CHG  = 2'd2;

    logic [17:0] exp_q[$];

    vend_sequencer dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .coin_valid_i(coin_valid),
        .coin_val_i  (coin_val),
        .coin_rej_o  (coin_rej),
        .sel_valid_i (sel_valid),
        .sel_id_i    (sel_id),
        .cancel_i    (cancel),
        .credit_o    (credit),
        .avail_o     (avail),
        .vend_req_o  (vend_req),
        .vend_id_o   (vend_id),
        .vend_ack_i  (vend_ack),
        .chg_req_o   (chg_req),
        .chg_coin_o  (chg_coin),
        .chg_ack_i   (chg_ack),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic expect_ev(input logic [1:0] kind, input logic [1:0] code, input logic [7:0] cr);
        exp_q.push_back({kind, 6'd0, code, cr});
    endtask

    task automatic observe(input logic [17:0] ev);
        logic [17:0] e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected: got event %0h expected none", ev);
        end else begin
            e = exp_q.pop_front();
            if (e !== ev) begin
                fails++;
                $display("FAIL sb_event: got %0h expected %0h", ev, e);
            end
        end
    endtask

    // Monitor: each refused coin, completed vend and ejected change coin is one event.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (coin_rej)             observe({K_REJ, 6'd0, 2'd0, credit});
                if (vend_req && vend_ack) observe({K_VEND, 6'd0, vend_id, credit});
                if (chg_req && chg_ack)   observe({K_CHG, 6'd0, chg_coin, credit});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [1:0] v);
        coin_valid = 1'b1;
        coin_val   = v;
        step();
        coin_valid = 1'b0;
    endtask

    task automatic sel(input logic [1:0] id);
        sel_valid = 1'b1;
        sel_id    = id;
        step();
        sel_valid = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
    endtask

    task automatic ack_vend();
        int n = 0;
        while (!vend_req && n < 20) begin
            step();
            n++;
        end
        tests++;
        if (!vend_req) begin
            fails++;
            $display("FAIL vend_wait: got vend_req=0 expected 1 within 20 cycles");
        end else begin
            vend_ack = 1'b1;
            step();
            vend_ack = 1'b0;
        end
    endtask

    task automatic ack_chg(input int hold);
        int n = 0;
        while (!chg_req && n < 20) begin
            step();
            n++;
        end
        tests++;
        if (!chg_req) begin
            fails++;
            $display("FAIL chg_wait: got chg_req=0 expected 1 within 20 cycles");
        end else begin
            chg_ack = 1'b1;
            repeat (hold) step();
            chg_ack = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        coin_valid = 1'b0; coin_val = 2'd0; sel_valid = 1'b0; sel_id = 2'd0;
        cancel = 1'b0; vend_ack = 1'b0; chg_ack = 1'b0;
        repeat (3) step();
        chk("reset_credit", credit, 8'd0);
        chk("reset_avail", avail, 4'b0000);
        chk("reset_outs", {vend_req, vend_id, chg_req, chg_coin, coin_rej, busy}, 8'd0);
        rst_n = 1'b1;
        step();

        // Coins 10 + 5, buy drink 1, no change.
        coin(2'b10);
        coin(2'b01);
        chk("t2_credit", credit, 8'd15);
        chk("t2_avail", avail, 4'b0011);
        expect_ev(K_VEND, 2'd1, 8'd0);
        sel(2'd1);
        chk("t2_vend", {vend_req, vend_id, busy}, {1'b1, 2'd1, 1'b1});
        chk("t2_credit_after", credit, 8'd0);
        ack_vend();
        step();
        chk("t2_idle", {vend_req, chg_req, busy}, 3'b000);

        // Credit 61, buy drink 3, change 10,10,10,5,1 with back-to-back acks.
        coin(2'b11);
        coin(2'b10);
        coin(2'b00);
        chk("t3_credit", credit, 8'd61);
        chk("t3_avail", avail, 4'b1111);
        expect_ev(K_VEND, 2'd3, 8'd36);
        sel(2'd3);
        chk("t3_credit_after", credit, 8'd36);
        ack_vend();
        chk("t3_chg_first", {chg_req, chg_coin}, {1'b1, 2'b10});
        expect_ev(K_CHG, 2'b10, 8'd36);
        expect_ev(K_CHG, 2'b10, 8'd26);
        expect_ev(K_CHG, 2'b10, 8'd16);
        expect_ev(K_CHG, 2'b01, 8'd6);
        expect_ev(K_CHG, 2'b00, 8'd1);
        ack_chg(5);
        chk("t3_done", {credit, chg_req, busy}, {8'd0, 1'b0, 1'b0});

        // MAX_CREDIT boundary.
        coin(2'b11); coin(2'b11);
        coin(2'b10); coin(2'b10); coin(2'b10); coin(2'b10);
        chk("t4_credit140", credit, 8'd140);
        expect_ev(K_REJ, 2'd0, 8'd140);
        coin(2'b11);
        chk("t4_rej_pulse", coin_rej, 1'b1);
        step();
        chk("t4_rej_one_cycle", coin_rej, 1'b0);
        chk("t4_credit_kept", credit, 8'd140);
        coin(2'b10);
        chk("t4_credit150", credit, 8'd150);
        expect_ev(K_REJ, 2'd0, 8'd150);
        coin(2'b00);
        chk("t4_credit_full", credit, 8'd150);
        do_cancel();
        expect_ev(K_CHG, 2'b11, 8'd150);
        expect_ev(K_CHG, 2'b11, 8'd100);
        expect_ev(K_CHG, 2'b11, 8'd50);
        ack_chg(1); step();
        ack_chg(1); step();
        ack_chg(1);
        chk("t4_drained", {credit, busy}, {8'd0, 1'b0});

        // Unaffordable selection, then cancel with a simultaneous coin.
        coin(2'b10); coin(2'b00); coin(2'b00);
        chk("t5_avail", avail, 4'b0001);
        sel(2'd2);
        chk("t5_sel_ignored", {vend_req, credit}, {1'b0, 8'd12});
        expect_ev(K_REJ, 2'd0, 8'd12);
        cancel = 1'b1; coin_valid = 1'b1; coin_val = 2'b01;
        step();
        cancel = 1'b0; coin_valid = 1'b0;
        chk("t5_change", {chg_req, chg_coin, credit}, {1'b1, 2'b10, 8'd12});
        expect_ev(K_CHG, 2'b10, 8'd12);
        expect_ev(K_CHG, 2'b00, 8'd2);
        expect_ev(K_CHG, 2'b00, 8'd1);
        ack_chg(1);
        ack_chg(1);
        ack_chg(1);
        chk("t5_done", {credit, busy}, {8'd0, 1'b0});

        // Coin during VEND, stray vend_ack in CHANGE and COLLECT.
        coin(2'b10); coin(2'b10);
        sel(2'd0);
        expect_ev(K_REJ, 2'd0, 8'd10);
        coin(2'b01);
        chk("t6_credit_vend", credit, 8'd10);
        expect_ev(K_VEND, 2'd0, 8'd10);
        ack_vend();
        vend_ack = 1'b1;
        step(); step();
        vend_ack = 1'b0;
        chk("t6_stray_ack", {chg_req, chg_coin, credit}, {1'b1, 2'b10, 8'd10});
        expect_ev(K_CHG, 2'b10, 8'd10);
        ack_chg(1);
        vend_ack = 1'b1;
        step();
        vend_ack = 1'b0;
        chk("t6_idle", {vend_req, chg_req, busy, credit}, {3'b000, 8'd0});

        // Asynchronous reset in the middle of CHANGE.
        coin(2'b11); coin(2'b01);
        do_cancel();
        chk("t7_in_change", {chg_req, chg_coin}, {1'b1, 2'b11});
        rst_n = 1'b0;
        #2;
        chk("t7_async_outs", {vend_req, chg_req, chg_coin, coin_rej, busy, credit}, {6'd0, 8'd0});
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();
        chk("t7_after_release", {credit, avail, busy}, {8'd0, 4'd0, 1'b0});

        repeat (3) step();
        chk("sb_pending", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vend_sequencer.md
# vend_sequencer

Sequencing controller for the drink vending datapath: accumulates inserted coins into a credit register, advertises which drinks are affordable, and issues one vend request per accepted selection. It then returns the remaining credit as change, one coin at a time, over a handshake with the coin ejector. It sits between the coin acceptor and selection buttons on one side and the dispenser and ejector actuators on the other.

## Interface
- PRICE0, 10, price of drink 0 (credit units)
- PRICE1, 15, price of drink 1
- PRICE2, 20, price of drink 2
- PRICE3, 25, price of drink 3
- MAX_CREDIT, 150, highest credit accepted; must be ≤ 255
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- coin_valid  input  1  one-cycle pulse: a coin was inserted
- coin_val  input  2  denomination: 00=1, 01=5, 10=10, 11=50
- coin_rej  output  1  one-cycle pulse: the coin seen last cycle was refused
- sel_valid  input  1  one-cycle pulse: drink selection
- sel_id  input  2  selected drink index
- cancel  input  1  one-cycle pulse: return all credit
- credit  output  8  current credit
- avail  output  4  avail[i] = (credit >= PRICEi), combinational from the credit register
- vend_req  output  1  dispense request, held until acknowledged
- vend_id  output  2  drink being dispensed; stable while vend_req=1
- vend_ack  input  1  dispenser done
- chg_req  output  1  eject-one-coin request, held until acknowledged
- chg_coin  output  2  denomination to eject (same encoding as coin_val); stable while chg_req=1
- chg_ack  input  1  ejector done
- busy  output  1  1 in VEND or CHANGE

## Operation
- States: COLLECT, VEND, CHANGE. Reset enters COLLECT.
- COLLECT priority per cycle: cancel > coin_valid > sel_valid. Lower-priority events in the same cycle are dropped.
- cancel:
  - credit>0 → CHANGE.
  - credit=0 → no effect.
  - A simultaneous coin is refused (coin_rej).
- coin_valid:
  - If credit + value ≤ MAX_CREDIT, credit += value.
  - Otherwise credit is unchanged and coin_rej pulses.
- sel_valid:
  - If avail[sel_id]=1: credit -= PRICE[sel_id], vend_id <= sel_id, go to VEND.
  - Otherwise ignored; stay in COLLECT with no state change.
- VEND: vend_req=1. On the vend_ack cycle, go to CHANGE if credit>0, else COLLECT.
- CHANGE:
  - chg_req=1; chg_coin is the greedy choice, the largest of 50/10/5/1 that is ≤ credit.
  - On the chg_ack cycle, credit -= chg_coin value.
  - If the new credit is 0, go to COLLECT; otherwise stay, and the next chg_req/chg_coin applies from the following cycle.
- Any coin_valid in VEND or CHANGE is refused (coin_rej). sel_valid and cancel are ignored there.
- Acks arriving while the corresponding req=0 are ignored.
- Arithmetic is unsigned 8-bit. Overflow cannot occur due to the MAX_CREDIT check; underflow cannot occur due to the avail/greedy rules.

## Timing
- Reset (reset=0, asynchronous):
  - credit=0, state=COLLECT.
  - vend_req, vend_id, chg_req, chg_coin, coin_rej, busy all 0.
- Reset asserted mid-VEND or mid-CHANGE aborts immediately; remaining credit is lost.
- coin → credit updated at the next clk edge. avail and credit are visible in the cycle after the coin pulse.
- coin_rej is registered: it asserts the cycle after the refused coin, for exactly 1 cycle.
- Accepted sel → vend_req=1 from the next cycle. vend_ack in the same cycle that vend_req is first seen is legal (minimum 1-cycle vend).
- vend_ack → chg_req=1 the next cycle (if credit>0).
- Each change coin takes at least 1 cycle. Back-to-back chg_ack cycles eject one coin per cycle.
- chg_coin is registered and recomputed only at an ack or on entry to CHANGE; it never changes while chg_req=1 without an ack.
- busy is asserted in the same cycles as vend_req or chg_req.

## Test plan
- Reset with reset=0 during CHANGE → all outputs 0 asynchronously; after release, credit=0, avail=0000.
- Coins 10, 5 → credit 15, avail=0011. sel_id=1 → vend_req=1, vend_id=1, credit=0. vend_ack → back in COLLECT, chg_req never asserted.
- Coins 50, 10, 1 (credit 61); sel_id=3 → credit 36. After vend_ack, chg_coin sequence is 10,10,10,5,1 with chg_ack each time; credit ends at 0 and the FSM is in COLLECT.
- Credit 140, insert 50 → coin_rej pulse, credit stays 140. Insert 10 → credit 150.
- Credit 12, sel_id=2 → ignored, no vend_req. Same-cycle cancel + coin(5) → coin_rej; change 10,1,1 is returned.
- Coin inserted during VEND → coin_rej, credit unchanged. vend_ack held high with no pending request → ignored.
